// File: rtl/trdb_filter.sv
// ============================================================================
//  Module   : trdb_filter
//  Brief    : Combinational trace-qualification filter. Five retirement
//             attributes (cause, tvec, tval, priv_lvl, iaddr) are each checked
//             against a programmable range window and/or exact-match value.
//             The instruction is qualified when every enabled filter accepts.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// trdb_filter_cmp : one field comparator (range window and/or exact match)
// ----------------------------------------------------------------------------
module trdb_filter_cmp #(
  parameter int W = 32
) (
  input  logic         filter_en,
  input  logic         range_mode,
  input  logic         equal_mode,
  input  logic [W-1:0] upper,
  input  logic [W-1:0] lower,
  input  logic [W-1:0] match,
  input  logic [W-1:0] value,
  output logic         hit
);

  logic in_range;
  logic eq;

  // Unsigned inclusive window; an inverted window (lower > upper) can never
  // satisfy both comparisons, so it naturally reads as empty.
  always_comb begin
    in_range = (lower <= value) && (value <= upper);
    eq       = (value == match);
    if (!filter_en || (!range_mode && !equal_mode)) begin
      hit = 1'b1;
    end else begin
      hit = (range_mode & in_range) | (equal_mode & eq);
    end
  end

endmodule

// ----------------------------------------------------------------------------
// trdb_filter : five comparators followed by an AND-reduce
// ----------------------------------------------------------------------------
module trdb_filter #(
  parameter int XLEN      = 32,
  parameter int CAUSE_LEN = 5,
  parameter int PRIV_LEN  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 cause_filter_i,
  input  logic [CAUSE_LEN-1:0] upper_cause_i,
  input  logic [CAUSE_LEN-1:0] lower_cause_i,
  input  logic [CAUSE_LEN-1:0] match_cause_i,
  input  logic                 cause_range_mode_i,
  input  logic                 cause_equal_mode_i,
  input  logic [CAUSE_LEN-1:0] cause_i,

  input  logic                 tvec_filter_i,
  input  logic [XLEN-1:2]      upper_tvec_i,
  input  logic [XLEN-1:2]      lower_tvec_i,
  input  logic [XLEN-1:2]      match_tvec_i,
  input  logic                 tvec_range_mode_i,
  input  logic                 tvec_equal_mode_i,
  input  logic [XLEN-1:2]      tvec_i,

  input  logic                 tval_filter_i,
  input  logic [XLEN-1:0]      upper_tval_i,
  input  logic [XLEN-1:0]      lower_tval_i,
  input  logic [XLEN-1:0]      match_tval_i,
  input  logic                 tval_range_mode_i,
  input  logic                 tval_equal_mode_i,
  input  logic [XLEN-1:0]      tval_i,

  input  logic                 priv_lvl_filter_i,
  input  logic [PRIV_LEN-1:0]  upper_priv_lvl_i,
  input  logic [PRIV_LEN-1:0]  lower_priv_lvl_i,
  input  logic [PRIV_LEN-1:0]  match_priv_lvl_i,
  input  logic                 priv_lvl_range_mode_i,
  input  logic                 priv_lvl_equal_mode_i,
  input  logic [PRIV_LEN-1:0]  priv_lvl_i,

  input  logic                 iaddr_filter_i,
  input  logic [XLEN-1:0]      upper_iaddr_i,
  input  logic [XLEN-1:0]      lower_iaddr_i,
  input  logic [XLEN-1:0]      match_iaddr_i,
  input  logic                 iaddr_range_mode_i,
  input  logic                 iaddr_equal_mode_i,
  input  logic [XLEN-1:0]      iaddr_i,

  output logic                 nc_qualified_o
);

  logic hit_cause;
  logic hit_tvec;
  logic hit_tval;
  logic hit_priv_lvl;
  logic hit_iaddr;

  // Clock and reset are part of the port contract but nothing is clocked yet.
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_i;

  trdb_filter_cmp #(.W(CAUSE_LEN)) u_cmp_cause (
    .filter_en  (cause_filter_i),
    .range_mode (cause_range_mode_i),
    .equal_mode (cause_equal_mode_i),
    .upper      (upper_cause_i),
    .lower      (lower_cause_i),
    .match      (match_cause_i),
    .value      (cause_i),
    .hit        (hit_cause)
  );

  // tvec bits 1:0 hold the vector mode and are not part of the address.
  trdb_filter_cmp #(.W(XLEN-2)) u_cmp_tvec (
    .filter_en  (tvec_filter_i),
    .range_mode (tvec_range_mode_i),
    .equal_mode (tvec_equal_mode_i),
    .upper      (upper_tvec_i),
    .lower      (lower_tvec_i),
    .match      (match_tvec_i),
    .value      (tvec_i),
    .hit        (hit_tvec)
  );

  trdb_filter_cmp #(.W(XLEN)) u_cmp_tval (
    .filter_en  (tval_filter_i),
    .range_mode (tval_range_mode_i),
    .equal_mode (tval_equal_mode_i),
    .upper      (upper_tval_i),
    .lower      (lower_tval_i),
    .match      (match_tval_i),
    .value      (tval_i),
    .hit        (hit_tval)
  );

  trdb_filter_cmp #(.W(PRIV_LEN)) u_cmp_priv_lvl (
    .filter_en  (priv_lvl_filter_i),
    .range_mode (priv_lvl_range_mode_i),
    .equal_mode (priv_lvl_equal_mode_i),
    .upper      (upper_priv_lvl_i),
    .lower      (lower_priv_lvl_i),
    .match      (match_priv_lvl_i),
    .value      (priv_lvl_i),
    .hit        (hit_priv_lvl)
  );

  trdb_filter_cmp #(.W(XLEN)) u_cmp_iaddr (
    .filter_en  (iaddr_filter_i),
    .range_mode (iaddr_range_mode_i),
    .equal_mode (iaddr_equal_mode_i),
    .upper      (upper_iaddr_i),
    .lower      (lower_iaddr_i),
    .match      (match_iaddr_i),
    .value      (iaddr_i),
    .hit        (hit_iaddr)
  );

  // Qualified only when every field accepts.
  always_comb begin
    nc_qualified_o = hit_cause & hit_tvec & hit_tval & hit_priv_lvl & hit_iaddr;
  end

endmodule

`default_nettype wire

// File: tb/tb_trdb_filter.sv
// ============================================================================
//  Module   : tb_trdb_filter
//  Brief    : Self-checking bench for trdb_filter: directed cases plus
//             randomized field programming checked against a rule model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trdb_filter;

  localparam int XLEN = 32;

  // Field index: 0 cause, 1 tvec, 2 tval, 3 priv_lvl, 4 iaddr
  localparam int NF = 5;
  int wd [NF] = '{5, 30, 32, 2, 32};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        en [NF];
  logic        rm [NF];
  logic        em [NF];
  logic [31:0] lo [NF];
  logic [31:0] hi [NF];
  logic [31:0] mt [NF];
  logic [31:0] vl [NF];

  logic              cause_filter_i, cause_range_mode_i, cause_equal_mode_i;
  logic [4:0]        upper_cause_i, lower_cause_i, match_cause_i, cause_i;
  logic              tvec_filter_i, tvec_range_mode_i, tvec_equal_mode_i;
  logic [XLEN-1:2]   upper_tvec_i, lower_tvec_i, match_tvec_i, tvec_i;
  logic              tval_filter_i, tval_range_mode_i, tval_equal_mode_i;
  logic [XLEN-1:0]   upper_tval_i, lower_tval_i, match_tval_i, tval_i;
  logic              priv_lvl_filter_i, priv_lvl_range_mode_i, priv_lvl_equal_mode_i;
  logic [1:0]        upper_priv_lvl_i, lower_priv_lvl_i, match_priv_lvl_i, priv_lvl_i;
  logic              iaddr_filter_i, iaddr_range_mode_i, iaddr_equal_mode_i;
  logic [XLEN-1:0]   upper_iaddr_i, lower_iaddr_i, match_iaddr_i, iaddr_i;
  logic              nc_qualified_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trdb_filter dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .cause_filter_i        (cause_filter_i),
    .upper_cause_i         (upper_cause_i),
    .lower_cause_i         (lower_cause_i),
    .match_cause_i         (match_cause_i),
    .cause_range_mode_i    (cause_range_mode_i),
    .cause_equal_mode_i    (cause_equal_mode_i),
    .cause_i               (cause_i),
    .tvec_filter_i         (tvec_filter_i),
    .upper_tvec_i          (upper_tvec_i),
    .lower_tvec_i          (lower_tvec_i),
    .match_tvec_i          (match_tvec_i),
    .tvec_range_mode_i     (tvec_range_mode_i),
    .tvec_equal_mode_i     (tvec_equal_mode_i),
    .tvec_i                (tvec_i),
    .tval_filter_i         (tval_filter_i),
    .upper_tval_i          (upper_tval_i),
    .lower_tval_i          (lower_tval_i),
    .match_tval_i          (match_tval_i),
    .tval_range_mode_i     (tval_range_mode_i),
    .tval_equal_mode_i     (tval_equal_mode_i),
    .tval_i                (tval_i),
    .priv_lvl_filter_i     (priv_lvl_filter_i),
    .upper_priv_lvl_i      (upper_priv_lvl_i),
    .lower_priv_lvl_i      (lower_priv_lvl_i),
    .match_priv_lvl_i      (match_priv_lvl_i),
    .priv_lvl_range_mode_i (priv_lvl_range_mode_i),
    .priv_lvl_equal_mode_i (priv_lvl_equal_mode_i),
    .priv_lvl_i            (priv_lvl_i),
    .iaddr_filter_i        (iaddr_filter_i),
    .upper_iaddr_i         (upper_iaddr_i),
    .lower_iaddr_i         (lower_iaddr_i),
    .match_iaddr_i         (match_iaddr_i),
    .iaddr_range_mode_i    (iaddr_range_mode_i),
    .iaddr_equal_mode_i    (iaddr_equal_mode_i),
    .iaddr_i               (iaddr_i),
    .nc_qualified_o        (nc_qualified_o)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Rule model: a field passes when unconstrained, otherwise it must hit an
  // enabled window or match; the instruction qualifies if all fields pass.
  function automatic logic model();
    logic q = 1'b1;
    for (int f = 0; f < NF; f++) begin
      logic h;
      if (!en[f] || (!rm[f] && !em[f]))
        h = 1'b1;
      else
        h = (rm[f] && (lo[f] <= vl[f]) && (vl[f] <= hi[f])) ||
            (em[f] && (vl[f] == mt[f]));
      q = q & h;
    end
    return q;
  endfunction

  task automatic drive();
    cause_filter_i = en[0]; cause_range_mode_i = rm[0]; cause_equal_mode_i = em[0];
    upper_cause_i = hi[0][4:0]; lower_cause_i = lo[0][4:0];
    match_cause_i = mt[0][4:0]; cause_i = vl[0][4:0];
    tvec_filter_i = en[1]; tvec_range_mode_i = rm[1]; tvec_equal_mode_i = em[1];
    upper_tvec_i = hi[1][29:0]; lower_tvec_i = lo[1][29:0];
    match_tvec_i = mt[1][29:0]; tvec_i = vl[1][29:0];
    tval_filter_i = en[2]; tval_range_mode_i = rm[2]; tval_equal_mode_i = em[2];
    upper_tval_i = hi[2]; lower_tval_i = lo[2]; match_tval_i = mt[2]; tval_i = vl[2];
    priv_lvl_filter_i = en[3]; priv_lvl_range_mode_i = rm[3]; priv_lvl_equal_mode_i = em[3];
    upper_priv_lvl_i = hi[3][1:0]; lower_priv_lvl_i = lo[3][1:0];
    match_priv_lvl_i = mt[3][1:0]; priv_lvl_i = vl[3][1:0];
    iaddr_filter_i = en[4]; iaddr_range_mode_i = rm[4]; iaddr_equal_mode_i = em[4];
    upper_iaddr_i = hi[4]; lower_iaddr_i = lo[4]; match_iaddr_i = mt[4]; iaddr_i = vl[4];
  endtask

  task automatic clear_all();
    for (int f = 0; f < NF; f++) begin
      en[f] = 1'b0; rm[f] = 1'b0; em[f] = 1'b0;
      lo[f] = '0; hi[f] = '0; mt[f] = '0; vl[f] = '0;
    end
  endtask

  // Inputs change just after the rising edge; output sampled on the falling edge.
  task automatic step(input string tag, input logic exp);
    @(posedge clk);
    drive();
    @(negedge clk);
    check(tag, nc_qualified_o, exp);
  endtask

  function automatic logic [31:0] pick(input logic [31:0] mask);
    if ($urandom_range(0, 3) == 0) return $urandom() & mask;
    return $urandom_range(0, 24) & mask;
  endfunction

  task automatic randomize_fields();
    for (int f = 0; f < NF; f++) begin
      logic [31:0] mask;
      int sel;
      mask = (wd[f] == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd[f]) - 32'd1);
      en[f] = ($urandom_range(0, 2) == 0);
      rm[f] = $urandom_range(0, 1) != 0;
      em[f] = $urandom_range(0, 1) != 0;
      lo[f] = pick(mask);
      hi[f] = pick(mask);
      mt[f] = pick(mask);
      sel = $urandom_range(0, 6);
      case (sel)
        0: vl[f] = lo[f];
        1: vl[f] = hi[f];
        2: vl[f] = mt[f];
        3: vl[f] = (hi[f] + 32'd1) & mask;
        4: vl[f] = (lo[f] - 32'd1) & mask;
        default: vl[f] = pick(mask);
      endcase
    end
  endtask

  initial begin
    clear_all();
    drive();

    // Reset held: output is still a pure function of inputs.
    for (int i = 0; i < 5; i++) begin
      lo[4] = $urandom(); vl[4] = $urandom(); vl[2] = $urandom();
      step("reset_all_off", 1'b1);
    end
    @(posedge clk);
    rst = 1'b0;

    // All filters off with arbitrary values.
    for (int i = 0; i < 4; i++) begin
      randomize_fields();
      for (int f = 0; f < NF; f++) en[f] = 1'b0;
      step("all_off", 1'b1);
    end

    // iaddr range window boundaries.
    clear_all();
    en[4] = 1; rm[4] = 1; lo[4] = 32'h1000; hi[4] = 32'h2000;
    vl[4] = 32'h1000; step("iaddr_lower_edge", 1'b1);
    vl[4] = 32'h2000; step("iaddr_upper_edge", 1'b1);
    vl[4] = 32'h0FFF; step("iaddr_below", 1'b0);
    vl[4] = 32'h2001; step("iaddr_above", 1'b0);

    // cause equality, then same vectors with filter off.
    clear_all();
    en[0] = 1; em[0] = 1; mt[0] = 2;
    vl[0] = 2; step("cause_eq_hit", 1'b1);
    vl[0] = 3; step("cause_eq_miss", 1'b0);
    en[0] = 0;
    vl[0] = 2; step("cause_off_2", 1'b1);
    vl[0] = 3; step("cause_off_3", 1'b1);

    // priv_lvl with both modes.
    clear_all();
    en[3] = 1; rm[3] = 1; em[3] = 1; lo[3] = 0; hi[3] = 1; mt[3] = 3;
    vl[3] = 3; step("priv_eq_hit", 1'b1);
    vl[3] = 0; step("priv_range_hit", 1'b1);
    vl[3] = 2; step("priv_miss", 1'b0);

    // Inverted tval window is empty.
    clear_all();
    en[2] = 1; rm[2] = 1; lo[2] = 32'h10; hi[2] = 32'h08; vl[2] = 32'h0C;
    step("tval_empty_range", 1'b0);
    vl[2] = 32'h10; step("tval_empty_at_lower", 1'b0);

    // Combined fields.
    clear_all();
    en[0] = 1; em[0] = 1; mt[0] = 7; vl[0] = 7;
    en[1] = 1; rm[1] = 1; lo[1] = 30'h100; hi[1] = 30'h200; vl[1] = 30'h180;
    en[4] = 1; rm[4] = 1; lo[4] = 32'h8000; hi[4] = 32'h9000; vl[4] = 32'h9004;
    step("combo_iaddr_miss", 1'b0);
    vl[4] = 32'h8800; step("combo_all_hit", 1'b1);
    en[2] = 1; rm[2] = 0; em[2] = 0; lo[2] = 32'h5; hi[2] = 32'h1; vl[2] = 32'hFF;
    step("combo_no_mode_pass", 1'b1);
    vl[1] = 30'h201; step("combo_tvec_miss", 1'b0);

    // Randomized programming, with reset toggled at random.
    for (int i = 0; i < 600; i++) begin
      randomize_fields();
      @(posedge clk);
      rst = ($urandom_range(0, 7) == 0);
      drive();
      @(negedge clk);
      check("random", nc_qualified_o, model());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trdb_filter.md
# trdb_filter

Combinational trace-qualification filter for the RISC-V trace encoder (trdb). It compares five instruction-retirement attributes (cause, tvec, tval, privilege level, instruction address) against software-programmed range/match windows. It asserts `nc_qualified_o` when every enabled filter accepts the current values. The packet emitter uses this output to decide whether the current instruction is qualified for tracing.

## Interface
Parameters (from `trdb_pkg`):
- `XLEN`, 32, architectural address/data width
- `CAUSE_LEN`, 5, exception/interrupt cause width
- `PRIV_LEN`, 2, privilege-level width

Ports (for each field F in {cause, tvec, tval, priv_lvl, iaddr}, the group below is repeated; field width W is CAUSE_LEN, XLEN-2 (bits [XLEN-1:2]), XLEN, PRIV_LEN, XLEN respectively):
- `clk_i`  in  1  clock; one clock, no state currently clocked
- `rst_i`  in  1  reset, synchronous, active-high; no effect on the combinational output
- `F_filter_i`  in  1  enable filtering on field F
- `upper_F_i`  in  W  inclusive upper bound of range window
- `lower_F_i`  in  W  inclusive lower bound of range window
- `match_F_i`  in  W  exact-match value
- `F_range_mode_i`  in  1  enable range comparison
- `F_equal_mode_i`  in  1  enable equality comparison
- `F_i`  in  W  current value of field F (tvec_i is [XLEN-1:2])
- `nc_qualified_o`  out  1  1 = current instruction passes all enabled filters

## Operation
- Per field F, compute `hit_F`:
  - `F_filter_i == 0` → `hit_F = 1`. Field is unconstrained.
  - `F_filter_i == 1`, both modes 0 → `hit_F = 1`. No constraint is programmed.
  - Otherwise `hit_F = (F_range_mode_i & in_range_F) | (F_equal_mode_i & eq_F)`.
  - `in_range_F = (lower_F_i <= F_i) & (F_i <= upper_F_i)`. The comparison is unsigned and inclusive at both ends.
  - `eq_F = (F_i == match_F_i)`.
- If `lower_F_i > upper_F_i`, the range is empty and `in_range_F = 0`. There is no wrap-around interpretation.
- `nc_qualified_o = hit_cause & hit_tvec & hit_tval & hit_priv_lvl & hit_iaddr`.
- tvec is compared on bits [XLEN-1:2] only, since bits 1:0 are the mode field and are excluded.
- Implement one reusable comparator per field, or one parameterised comparator instantiated five times. The AND-reduce follows the comparators.

## Timing
- Fully combinational: `nc_qualified_o` is valid in the same cycle its inputs are stable, with zero latency.
- No registers, no handshake.
- `clk_i` and `rst_i` do not affect the output. Asserting `rst_i` mid-operation leaves `nc_qualified_o` a pure function of the current inputs.
- Inputs change at the rising edge; the output must be settled and checkable by the following falling edge.
- Any change on any input propagates immediately with no glitch-state requirements beyond settling within half a cycle.

## Test plan
- All `F_filter_i = 0`, arbitrary values → `nc_qualified_o = 1`.
- iaddr filter on, range mode, lower=0x1000, upper=0x2000:
  - iaddr=0x1000 → 1
  - iaddr=0x2000 → 1
  - iaddr=0x0FFF → 0
  - iaddr=0x2001 → 0
- cause filter on, equal mode, match=5'd2: cause=2 → 1; cause=3 → 0. Same vectors with cause filter off → 1.
- priv_lvl filter on with both modes, lower=0, upper=1, match=3:
  - priv=3 → 1 (equal hit)
  - priv=0 → 1 (range hit)
  - priv=2 → 0
- tval filter on, range mode, lower=0x10 > upper=0x08, tval=0x0C → 0 (empty range).
- Combined: cause equal hit, tvec range hit, iaddr range miss → 0. Fixing iaddr into range → 1. Filter enabled with both modes 0 → that field passes.
